rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single register-file write port (RegWrite/RDaddr/RDdata/is_pos) between the core writeback stage and up to NUM_REQ accelerator result sources, e.g. FC and max-pool units. Core writeback has fixed top priority. Accelerators are served round-robin behind it. A starvation counter forces a one-cycle core writeback stall so accelerators always make progress. Outputs are registered at posedge so they are stable before the register file's negedge write.

## Interface
- NUM_REQ, 2: number of accelerator requesters (≥2)
- ADDR_W, 5: register address width
- DATA_W, 32: write data width
- POS_W, 4: position-tag width
- STARVE_LIMIT, 4: consecutive blocked cycles before forcing a stall (≥1)
- clk_i  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- wb_valid_i  in  1  core writeback request; always accepted, no ready
- wb_addr_i / wb_data_i / wb_pos_i  in  ADDR_W / DATA_W / POS_W  core writeback payload
- acc_valid_i  in  NUM_REQ  per-accelerator request
- acc_addr_i / acc_data_i / acc_pos_i  in  NUM_REQ×ADDR_W / ×DATA_W / ×POS_W  packed payloads; requester i occupies slice i
- acc_ready_o  out  NUM_REQ  one-hot-or-zero grant (combinational)
- RegWrite_o / RDaddr_o / RDdata_o / is_pos_o  out  1 / ADDR_W / DATA_W / POS_W  registered write port to the register file
- stall_o  out  1  registered; core must hold writeback this cycle
- error_o  out  1  sticky; core violated stall_o

## Operation
- Per cycle, select one winner:
  - If wb_valid_i is 1, the winner is writeback, even during a stall, and every acc_ready_o bit is 0.
  - Otherwise, the winner is the first requester i with acc_valid_i[i]=1, searching from rr_ptr upward with wrap.
- acc_ready_o[i]=1 only for that requester. A transfer happens when valid and ready are both 1 at a posedge.
- Requesters hold valid and payload stable until accepted. Ready may depend on valid (no combinational loop back into valid).
- On a transfer from requester i, rr_ptr becomes (i+1) mod NUM_REQ. rr_ptr is unchanged on writeback-only or idle cycles.
- Write register: RegWrite_o is loaded with 1 and addr/data/pos with the winner's payload. With no winner, RegWrite_o is 0 and addr/data/pos hold their last value.
- Address 0 is not special-cased; it passes through like any other address.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - increments, saturating, when any acc_valid_i is 1 and writeback wins;
  - clears on any accelerator transfer, or when no acc_valid_i is 1.
- When starve_cnt reaches STARVE_LIMIT, stall_o is 1 in the next cycle only, and starve_cnt clears.
  - In a stall cycle the core must drive wb_valid_i=0, so the round-robin winner is granted.
  - If wb_valid_i is 1 during stall_o anyway, writeback still wins and error_o sets, staying set until reset.
- States: IDLE (no requests), GRANT (accelerator served), BLOCKED (writeback wins while an accelerator waits), STALL (stall_o high). STALL always returns to IDLE or GRANT after one cycle.

## Timing
- Reset values: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, is_pos_o=0, stall_o=0, error_o=0, rr_ptr=0, starve_cnt=0. acc_ready_o follows the combinational rule with reset state.
- Latency: a request accepted at posedge k drives the write port in cycle k+1; the register file captures it at the negedge inside cycle k+1.
- Throughput: one write per cycle, with no bubble between back-to-back grants.
- Simultaneous writeback and accelerator requests: writeback is written, and the accelerator waits with ready=0.
- Reset mid-operation: a registered but uncommitted write is dropped (RegWrite_o forced to 0). Unaccepted requests simply remain pending.
- A valid dropped without a transfer is a protocol violation; behaviour is undefined, with no check.

## Structure
- rf_arb_pkg holds the default widths (ADDR_W, DATA_W, POS_W), the STARVE_LIMIT default and the state enum (IDLE, GRANT, BLOCKED, STALL).
- One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; output gnt[N], one-hot. Purely combinational.
- The top level owns the write register, rr_ptr, starve_cnt, the stall/error flags and payload muxing.

## Test plan
- Reset, then acc_valid=2'b11 with no writeback → grants go acc0, acc1, acc0 on consecutive cycles, and RegWrite_o is 1 in each following cycle with the matching RDaddr_o/RDdata_o.
- wb_valid=1 (addr 5, data 32'h07_53_32_0c) together with acc0 valid → addr 5 is written in the next cycle; acc_ready_o=0.
- With STARVE_LIMIT=4, wb_valid held 1 while acc1 is valid for 4 cycles → stall_o=1 in cycle 5; if the core drops wb_valid, acc1 is granted and starve_cnt=0.
- wb_valid=1 while stall_o=1 → writeback is written, error_o=1 and stays 1 through later traffic until reset_n=0.
- reset_n asserted in the cycle after an acc0 acceptance → RegWrite_o=0 immediately, and no write to the target address is observed.
- Idle with no requests → RegWrite_o=0, RDaddr_o/RDdata_o hold their previous values, and rr_ptr is unchanged.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - default widths, starvation limit and state encoding for rf_write_arbiter
package rf_arb_pkg;

    // Default payload widths of the register-file write port
    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_POS_W        = 4;

    // Consecutive blocked cycles tolerated before the core is stalled for one cycle
    localparam int DEF_STARVE_LIMIT = 4;

    // IDLE: nothing served, GRANT: accelerator served, BLOCKED: writeback won over
    // a waiting accelerator, STALL: stall_o is high for exactly this cycle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BLOCKED = 2'd2,
        STALL   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, first request at or above ptr with wrap
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_req_hi;
    logic [N-1:0] w_gnt_hi;
    logic [N-1:0] w_gnt_lo;

    // Thermometer mask selecting positions at or above the pointer
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(ptr));
        end
    end

    assign w_req_hi = req & w_mask;

    // Lowest set bit of the masked and unmasked requests; scanning downward lets the lowest index win
    always_comb begin
        w_gnt_hi = '0;
        w_gnt_lo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_hi[i]) begin
                w_gnt_hi    = '0;
                w_gnt_hi[i] = 1'b1;
            end
            if (req[i]) begin
                w_gnt_lo    = '0;
                w_gnt_lo[i] = 1'b1;
            end
        end
    end

    // Requests above the pointer take precedence; otherwise wrap to the lowest request
    assign gnt = (|w_req_hi) ? w_gnt_hi : w_gnt_lo;

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between core writeback and accelerators
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int POS_W        = DEF_POS_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                      clk_i,
    input  logic                      reset_n,
    input  logic                      wb_valid_i,
    input  logic [ADDR_W-1:0]         wb_addr_i,
    input  logic [DATA_W-1:0]         wb_data_i,
    input  logic [POS_W-1:0]          wb_pos_i,
    input  logic [NUM_REQ-1:0]        acc_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] acc_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] acc_data_i,
    input  logic [NUM_REQ*POS_W-1:0]  acc_pos_i,
    output logic [NUM_REQ-1:0]        acc_ready_o,
    output logic                      RegWrite_o,
    output logic [ADDR_W-1:0]         RDaddr_o,
    output logic [DATA_W-1:0]         RDdata_o,
    output logic [POS_W-1:0]          is_pos_o,
    output logic                      stall_o,
    output logic                      error_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               r_error;
    logic               r_regwrite;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [POS_W-1:0]   r_pos;

    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_acc_any;
    logic               w_acc_xfer;
    logic               w_blocked;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [ADDR_W-1:0]  w_acc_addr;
    logic [DATA_W-1:0]  w_acc_data;
    logic [POS_W-1:0]   w_acc_pos;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_stall_trig;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req (acc_valid_i),
        .ptr (r_rr_ptr),
        .gnt (w_rr_gnt)
    );

    // Writeback always wins, so accelerators only see ready on cycles without writeback
    assign w_ready    = wb_valid_i ? '0 : w_rr_gnt;
    assign w_acc_any  = |acc_valid_i;
    assign w_acc_xfer = |(acc_valid_i & w_ready);
    assign w_blocked  = wb_valid_i & w_acc_any;

    // Select the granted accelerator's payload slice and remember its index
    always_comb begin
        w_win_idx  = '0;
        w_acc_addr = '0;
        w_acc_data = '0;
        w_acc_pos  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rr_gnt[i]) begin
                w_win_idx  = PTR_W'(i);
                w_acc_addr = acc_addr_i[i*ADDR_W +: ADDR_W];
                w_acc_data = acc_data_i[i*DATA_W +: DATA_W];
                w_acc_pos  = acc_pos_i[i*POS_W +: POS_W];
            end
        end
    end

    assign w_ptr_next = (w_win_idx == PTR_LAST) ? '0 : w_win_idx + PTR_W'(1);

    // Starvation bookkeeping; a stall is never re-triggered from inside the stall cycle itself
    always_comb begin
        w_cnt_inc    = (r_starve_cnt == CNT_LIMIT) ? r_starve_cnt : r_starve_cnt + CNT_W'(1);
        w_cnt_next   = r_starve_cnt;
        w_stall_trig = 1'b0;
        if (w_acc_xfer || !w_acc_any) begin
            w_cnt_next = '0;
        end else if (w_blocked) begin
            w_cnt_next   = w_cnt_inc;
            w_stall_trig = (r_state != STALL) && (w_cnt_inc == CNT_LIMIT);
        end
    end

    // Next-state decode; STALL lasts one cycle and falls back to GRANT or IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            STALL: begin
                w_next_state = w_acc_xfer ? GRANT : IDLE;
            end
            default: begin
                if (w_stall_trig)
                    w_next_state = STALL;
                else if (w_acc_xfer)
                    w_next_state = GRANT;
                else if (w_blocked)
                    w_next_state = BLOCKED;
                else
                    w_next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Round-robin pointer advances past the requester that just transferred
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n)
            r_rr_ptr <= '0;
        else if (w_acc_xfer)
            r_rr_ptr <= w_ptr_next;
    end

    // Starvation counter clears when it fires the stall
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n)
            r_starve_cnt <= '0;
        else if (w_stall_trig)
            r_starve_cnt <= '0;
        else
            r_starve_cnt <= w_cnt_next;
    end

    // Sticky flag for a writeback issued while the core was told to stall
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n)
            r_error <= 1'b0;
        else if ((r_state == STALL) && wb_valid_i)
            r_error <= 1'b1;
    end

    // Registered write port; payload holds its last value when nothing wins
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_regwrite <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_pos      <= '0;
        end else if (wb_valid_i) begin
            r_regwrite <= 1'b1;
            r_addr     <= wb_addr_i;
            r_data     <= wb_data_i;
            r_pos      <= wb_pos_i;
        end else if (w_acc_xfer) begin
            r_regwrite <= 1'b1;
            r_addr     <= w_acc_addr;
            r_data     <= w_acc_data;
            r_pos      <= w_acc_pos;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    assign acc_ready_o = w_ready;
    assign RegWrite_o  = r_regwrite;
    assign RDaddr_o    = r_addr;
    assign RDdata_o    = r_data;
    assign is_pos_o    = r_pos;
    assign stall_o     = (r_state == STALL);
    assign error_o     = r_error;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clk_i;
    logic        reset_n;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic [3:0]  wb_pos_i;
    logic [1:0]  acc_valid_i;
    logic [9:0]  acc_addr_i;
    logic [63:0] acc_data_i;
    logic [7:0]  acc_pos_i;
    logic [1:0]  acc_ready_o;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [3:0]  is_pos_o;
    logic        stall_o;
    logic        error_o;

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  p;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [1:0]  exp_ready = 2'b00;
    logic        exp_stall = 1'b0;
    logic        exp_error = 1'b0;
    logic [4:0]  last_a = '0;
    logic [31:0] last_d = '0;
    logic [3:0]  last_p = '0;

    logic [4:0]  A_ADDR [2] = '{5'd3, 5'd9};
    logic [31:0] A_DATA [2] = '{32'hA0A0_0001, 32'hB1B1_0002};
    logic [3:0]  A_POS  [2] = '{4'd1, 4'd2};

    rf_write_arbiter dut (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .wb_valid_i  (wb_valid_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .wb_pos_i    (wb_pos_i),
        .acc_valid_i (acc_valid_i),
        .acc_addr_i  (acc_addr_i),
        .acc_data_i  (acc_data_i),
        .acc_pos_i   (acc_pos_i),
        .acc_ready_o (acc_ready_o),
        .RegWrite_o  (RegWrite_o),
        .RDaddr_o    (RDaddr_o),
        .RDdata_o    (RDdata_o),
        .is_pos_o    (is_pos_o),
        .stall_o     (stall_o),
        .error_o     (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        chk("acc_ready", 64'(acc_ready_o), 64'(exp_ready));
        chk("stall", 64'(stall_o), 64'(exp_stall));
        chk("error", 64'(error_o), 64'(exp_error));
        if (!reset_n) begin
            exp_q.delete();
            last_a = '0;
            last_d = '0;
            last_p = '0;
            chk("rst_regwrite", 64'(RegWrite_o), 64'd0);
            chk("rst_addr", 64'(RDaddr_o), 64'd0);
            chk("rst_data", 64'(RDdata_o), 64'd0);
            chk("rst_pos", 64'(is_pos_o), 64'd0);
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
            mon_e = exp_q.pop_front();
            chk("wr_regwrite", 64'(RegWrite_o), 64'd1);
            chk("wr_addr", 64'(RDaddr_o), 64'(mon_e.a));
            chk("wr_data", 64'(RDdata_o), 64'(mon_e.d));
            chk("wr_pos", 64'(is_pos_o), 64'(mon_e.p));
            last_a = mon_e.a;
            last_d = mon_e.d;
            last_p = mon_e.p;
        end else begin
            chk("idle_regwrite", 64'(RegWrite_o), 64'd0);
            chk("hold_addr", 64'(RDaddr_o), 64'(last_a));
            chk("hold_data", 64'(RDdata_o), 64'(last_d));
            chk("hold_pos", 64'(is_pos_o), 64'(last_p));
        end
    end

    task automatic drive(input logic wbv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] wp, input logic [1:0] av, input logic [1:0] er,
                         input logic es, input logic ee, input logic ew,
                         input logic [4:0] ea, input logic [31:0] ed, input logic [3:0] ep);
        wr_t e;
        wb_valid_i  = wbv;
        wb_addr_i   = wa;
        wb_data_i   = wd;
        wb_pos_i    = wp;
        acc_valid_i = av;
        exp_ready   = er;
        exp_stall   = es;
        exp_error   = ee;
        if (ew) begin
            e.cyc = cyc;
            e.a   = ea;
            e.d   = ed;
            e.p   = ep;
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic ee);
        drive(1'b0, '0, '0, '0, 2'b00, 2'b00, 1'b0, ee, 1'b0, '0, '0, '0);
    endtask

    task automatic acc(input logic [1:0] av, input logic [1:0] er, input logic es,
                       input logic ee, input int w);
        drive(1'b0, '0, '0, '0, av, er, es, ee, 1'b1, A_ADDR[w], A_DATA[w], A_POS[w]);
    endtask

    task automatic wb(input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] wp,
                      input logic [1:0] av, input logic es, input logic ee);
        drive(1'b1, wa, wd, wp, av, 2'b00, es, ee, 1'b1, wa, wd, wp);
    endtask

    initial begin
        reset_n     = 1'b0;
        wb_valid_i  = 1'b0;
        wb_addr_i   = '0;
        wb_data_i   = '0;
        wb_pos_i    = '0;
        acc_valid_i = 2'b00;
        acc_addr_i  = {A_ADDR[1], A_ADDR[0]};
        acc_data_i  = {A_DATA[1], A_DATA[0]};
        acc_pos_i   = {A_POS[1], A_POS[0]};
        repeat (3) @(posedge clk_i);
        #1;
        reset_n = 1'b1;

        // Round robin from reset: acc0, acc1, acc0 back to back, then idle hold
        acc(2'b11, 2'b01, 1'b0, 1'b0, 0);
        acc(2'b11, 2'b10, 1'b0, 1'b0, 1);
        acc(2'b11, 2'b01, 1'b0, 1'b0, 0);
        idle(1'b0);
        idle(1'b0);
        // Pointer kept through idle cycles, so acc1 is next
        acc(2'b11, 2'b10, 1'b0, 1'b0, 1);

        // Writeback beats a waiting accelerator
        wb(5'd5, 32'h0753_320c, 4'd7, 2'b01, 1'b0, 1'b0);
        acc(2'b01, 2'b01, 1'b0, 1'b0, 0);
        idle(1'b0);

        // Starvation: four blocked cycles then a one-cycle stall serving acc1
        for (int k = 0; k < 4; k++)
            wb(5'(10 + k), 32'h100 + 32'(k), 4'(k), 2'b10, 1'b0, 1'b0);
        acc(2'b10, 2'b10, 1'b1, 1'b0, 1);
        idle(1'b0);

        // Starvation again, core ignores the stall and raises the sticky error
        for (int k = 0; k < 4; k++)
            wb(5'(20 + k), 32'h200 + 32'(k), 4'(k + 4), 2'b01, 1'b0, 1'b0);
        wb(5'd25, 32'h0000_000E, 4'hE, 2'b01, 1'b1, 1'b0);
        acc(2'b01, 2'b01, 1'b0, 1'b1, 0);
        idle(1'b1);
        acc(2'b10, 2'b10, 1'b0, 1'b1, 1);
        idle(1'b1);

        // Reset in the cycle after an acc0 acceptance drops the pending write
        acc(2'b01, 2'b01, 1'b0, 1'b1, 0);
        acc_valid_i = 2'b00;
        exp_ready   = 2'b00;
        exp_error   = 1'b0;
        reset_n     = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n = 1'b1;
        idle(1'b0);
        idle(1'b0);
        // Pointer back to zero after reset
        acc(2'b11, 2'b01, 1'b0, 1'b0, 0);
        idle(1'b0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
